// File: rtl/spart_tx_arbiter.sv
// spart_tx_arbiter: round-robin arbiter sharing the SPART transmitter, one byte per tbr cycle.
module spart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W = 8,
  parameter int ACK_TIMEOUT = 8,
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int CW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tbr,
  output logic [1:0]                ioaddr,
  output logic                      iorw,
  output logic                      iocs,
  output logic [DATA_W-1:0]         tx_data,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      ack_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] last_q, last_d, gid_q, gid_d, g, idx;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, found, take;
  // descending scan so the smallest offset after last_q is written last and wins
  always_comb begin
    g = '0;
    idx = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        g = idx;
        found = 1'b1;
      end
    end
  end
  assign take = state_q == IDLE && tbr && found;
  assign req_ready = (take && !rst) ? NUM_REQ'(1) << g : '0;
  assign iocs = state_q == ISSUE;
  assign iorw = !iocs;
  assign ioaddr = iocs ? 2'b00 : 2'b01;
  assign tx_data = tx_q;
  assign grant_id = gid_q;
  assign busy = state_q != IDLE;
  assign ack_err = err_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    gid_d = gid_q;
    tx_d = tx_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (take) begin
        state_d = ISSUE;
        tx_d = req_data[g*DATA_W +: DATA_W];
        gid_d = g;
        last_d = g;
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: if (!tbr) state_d = WAIT_HIGH;
        else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          err_d = 1'b1;
          state_d = ISSUE;
        end else cnt_d = cnt_q + 1'b1;
      WAIT_HIGH: if (tbr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= GW'(NUM_REQ - 1);
      gid_q <= '0;
      tx_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gid_q <= gid_d;
      tx_q <= tx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/spart_tx_arbiter.md
Name: spart_tx_arbiter

Overview:
Round-robin arbiter that shares the SPART transmitter between NUM_REQ byte producers, for example the CPU store path and a debug/monitor engine. It accepts one byte at a time over a valid/ready handshake. It then issues a single-cycle transmit-buffer write on the SPART I/O bus and tracks the transmitter's tbr flag until that byte has been fully shipped. Only then does it grant the next requester. It sits between the producers and the SPART bus interface, and it is the only driver of ioaddr/iorw/iocs for transmit writes.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 8, byte width
ACK_TIMEOUT, 8, cycles to wait for tbr to drop after a write strobe before re-issuing it

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot accept strobe
tbr  input  1  transmit buffer ready, from the SPART transmitter
ioaddr  output  2  SPART address
iorw  output  1  1 = read, 0 = write
iocs  output  1  SPART chip select
tx_data  output  DATA_W  byte driven on the SPART databus during a write
grant_id  output  clog2(NUM_REQ)  index of the current or last granted requester
busy  output  1  high in every state except IDLE
ack_err  output  1  sticky flag: a write strobe timed out

Behaviour:
- Interface: one clock (clk); rst is asynchronous, active-high. All state is cleared immediately on rst assertion.
- Reset values:
  - state = IDLE
  - iocs = 0, iorw = 1, ioaddr = 2'b01
  - tx_data = 0, grant_id = 0, busy = 0, ack_err = 0, req_ready = 0
  - round-robin pointer last = NUM_REQ-1, so requester 0 wins first
- Bus idle values outside ISSUE: iocs = 0, iorw = 1, ioaddr = 2'b01. This can never form a transmit write.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - If tbr = 1 and any req_valid is set, grant g = the first valid index searching last+1, last+2, … modulo NUM_REQ.
  - req_ready[g] is asserted combinationally in that same cycle. It depends only on state, tbr and req_valid.
  - On the clock edge: tx_data <= req_data[g], grant_id <= g, last <= g, and state goes to ISSUE.
  - If tbr = 0, no grant is made, whatever req_valid shows.
- ISSUE:
  - Exactly one cycle with iocs = 1, iorw = 0, ioaddr = 2'b00; tx_data is held.
  - Timeout counter is cleared to 0; state goes to WAIT_LOW.
- WAIT_LOW:
  - If tbr = 0, go to WAIT_HIGH.
  - Otherwise the counter increments each cycle. When it reaches ACK_TIMEOUT-1 with tbr still 1:
    - ack_err <= 1 (sticky until rst);
    - state goes to ISSUE, re-sending the same tx_data.
  - No limit on retries.
- WAIT_HIGH: stay until tbr = 1, then go to IDLE. A new grant can occur in the very next cycle.
- Latency: a valid seen in IDLE with tbr = 1 at cycle 0 gives req_ready at cycle 0 and the write strobe at cycle 1.
- Handshake rules:
  - A requester holds req_valid and req_data stable until it sees req_ready.
  - Data is sampled only in the cycle where req_ready is high.
  - req_valid may drop without a grant; the byte is simply not sent.
  - At most one req_ready bit is high in any cycle, and none outside IDLE.
- Fairness: with k requesters continuously valid, each is granted exactly once per k grants.
- Simultaneous events:
  - tbr rising in the same cycle the FSM enters IDLE is honoured next cycle.
  - A req_valid edge arriving during busy waits and does not pre-empt the current byte.
- Reset mid-operation: any state returns to IDLE and all outputs go to reset values. No partial or extra strobe is generated. The round-robin pointer resets.
- Width rules: grant_id width is clog2(NUM_REQ), minimum 1. The timeout counter is wide enough to hold ACK_TIMEOUT-1.

Test Plan:
- Single byte: tbr = 1, req_valid = 01, req_data[0] = 8'hA5.
  - req_ready = 01 in that cycle; next cycle iocs = 1, iorw = 0, ioaddr = 00, tx_data = A5.
  - Model drops tbr, then raises it after 160 cycles; busy falls one cycle after tbr rises.
- Contention: both requesters always valid, bytes 11, 22, 33, 44.
  - Grant order 0, 1, 0, 1; exactly one write strobe per grant; never two strobes before tbr has cycled low→high.
- Blocked start: tbr = 0 with req_valid = 11 for 50 cycles.
  - req_ready stays 00 and iocs stays 0; raising tbr produces a grant to requester 0 in the same cycle.
- Timeout: model never drops tbr after the strobe.
  - ack_err = 1 after 8 cycles in WAIT_LOW and the strobe repeats with the same tx_data.
  - When the model then drops tbr, the sequence completes and ack_err stays 1.
- Reset mid-byte: assert rst during WAIT_HIGH.
  - Outputs go to reset values immediately; after release, requester 0 wins the first grant even if requester 1 was next in rotation.
- NUM_REQ = 4, only requester 2 valid for 3 bytes.
  - Three consecutive grants to requester 2 with grant_id = 2, each waiting for its own tbr cycle.
